// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the transmitter and the receiver.
package uart_pkg;

    localparam int unsigned DATA_W_DEF     = 8;
    localparam int unsigned OVERSAMPLE_DEF = 16;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop,
        StBreakWait
    } uart_state_e;

    // Expected parity bit: p_sel=0 -> odd (~^data), p_sel=1 -> even (^data).
    // Data is zero-extended by callers; zero bits do not change the XOR.
    function automatic logic parity_bit(input logic [31:0] data, input logic p_sel);
        return p_sel ? (^data) : (~^data);
    endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for a single asynchronous input bit.
module uart_sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    // Two-stage capture; both flops reset to the line's idle level.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start, DATA_W bits LSB first, parity, stop; 16x oversampled.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEF,
    parameter int unsigned DATA_W     = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              baud_tick_rx,
    input  logic              rx_d_in,
    input  logic              p_sel,
    output logic [DATA_W-1:0] rx_d_out,
    output logic              rx_valid,
    output logic              parity_err,
    output logic              frame_err,
    output logic              rx_busy
);

    localparam int unsigned TICK_W = $clog2(OVERSAMPLE);
    localparam int unsigned BIT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [TICK_W-1:0] TICK_MID  = TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TICK_W-1:0] TICK_END  = TICK_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);

    logic rx_s;

    uart_state_e       state_q, state_d;
    logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
    logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              par_q, par_d;
    logic              p_sel_q, p_sel_d;
    logic [DATA_W-1:0] rx_d_out_q, rx_d_out_d;
    logic              parity_err_q, parity_err_d;
    logic              frame_err_q, frame_err_d;
    logic              rx_valid_q, rx_valid_d;
    logic [DATA_W:0]   shift_ext;

    uart_sync2 #(
        .RST_VAL (1'b1)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx_d_in),
        .q   (rx_s)
    );

    // New bit enters at the MSB so the byte assembles LSB first.
    assign shift_ext = {rx_s, shift_q};

    // Next-state logic; everything advances only on baud ticks except the valid pulse.
    always_comb begin
        state_d      = state_q;
        tick_cnt_d   = tick_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        par_d        = par_q;
        p_sel_d      = p_sel_q;
        rx_d_out_d   = rx_d_out_q;
        parity_err_d = parity_err_q;
        frame_err_d  = frame_err_q;
        rx_valid_d   = 1'b0;

        if (baud_tick_rx) begin
            unique case (state_q)
                StIdle: begin
                    if (!rx_s) begin
                        state_d    = StStart;
                        tick_cnt_d = '0;
                        p_sel_d    = p_sel;
                    end
                end
                StStart: begin
                    if (tick_cnt_q == TICK_MID) begin
                        tick_cnt_d = '0;
                        if (!rx_s) begin
                            state_d   = StData;
                            bit_cnt_d = '0;
                        end else begin
                            // Start bit did not survive to mid-bit: treat as a glitch.
                            state_d = StIdle;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + TICK_W'(1);
                    end
                end
                StData: begin
                    if (tick_cnt_q == TICK_END) begin
                        shift_d    = shift_ext[DATA_W:1];
                        tick_cnt_d = '0;
                        bit_cnt_d  = bit_cnt_q + BIT_W'(1);
                        if (bit_cnt_q == BIT_LAST) begin
                            state_d   = StParity;
                            bit_cnt_d = '0;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + TICK_W'(1);
                    end
                end
                StParity: begin
                    if (tick_cnt_q == TICK_END) begin
                        par_d      = rx_s;
                        tick_cnt_d = '0;
                        state_d    = StStop;
                    end else begin
                        tick_cnt_d = tick_cnt_q + TICK_W'(1);
                    end
                end
                StStop: begin
                    if (tick_cnt_q == TICK_END) begin
                        rx_d_out_d   = shift_q;
                        parity_err_d = (par_q != parity_bit(32'(shift_q), p_sel_q));
                        frame_err_d  = ~rx_s;
                        rx_valid_d   = 1'b1;
                        tick_cnt_d   = '0;
                        // A low stop bit means the line may be held in break; wait it out.
                        state_d      = rx_s ? StIdle : StBreakWait;
                    end else begin
                        tick_cnt_d = tick_cnt_q + TICK_W'(1);
                    end
                end
                StBreakWait: begin
                    if (rx_s) begin
                        state_d = StIdle;
                    end
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StIdle;
            tick_cnt_q   <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            par_q        <= 1'b0;
            p_sel_q      <= 1'b0;
            rx_d_out_q   <= '0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            rx_valid_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            tick_cnt_q   <= tick_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            par_q        <= par_d;
            p_sel_q      <= p_sel_d;
            rx_d_out_q   <= rx_d_out_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            rx_valid_q   <= rx_valid_d;
        end
    end

    assign rx_d_out   = rx_d_out_q;
    assign rx_valid   = rx_valid_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign rx_busy    = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx.
module tb_uart_rx;

    localparam int TICK_DIV = 4;               // clk cycles per baud tick
    localparam int BIT_CLK  = TICK_DIV * 16;   // clk cycles per bit

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       baud_tick_rx = 1'b0;
    logic       rx_d_in = 1'b1;
    logic       p_sel = 1'b0;
    logic [7:0] rx_d_out;
    logic       rx_valid;
    logic       parity_err;
    logic       frame_err;
    logic       rx_busy;

    int         checks = 0;
    int         errors = 0;
    int         valid_cnt = 0;
    logic [7:0] cap_last = 8'h00;
    logic [7:0] cap_prev = 8'h00;

    uart_rx #(
        .OVERSAMPLE (16),
        .DATA_W     (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .baud_tick_rx (baud_tick_rx),
        .rx_d_in      (rx_d_in),
        .p_sel        (p_sel),
        .rx_d_out     (rx_d_out),
        .rx_valid     (rx_valid),
        .parity_err   (parity_err),
        .frame_err    (frame_err),
        .rx_busy      (rx_busy)
    );

    always #5 clk = ~clk;

    // Baud tick: one clk high every TICK_DIV clocks.
    initial begin : tick_gen
        int cnt;
        cnt = 0;
        forever begin
            @(negedge clk);
            baud_tick_rx = (cnt == TICK_DIV - 1);
            cnt = (cnt + 1) % TICK_DIV;
        end
    end

    // Count valid pulses (a stretched pulse counts twice) and keep the last two bytes.
    initial begin : valid_mon
        forever begin
            @(negedge clk);
            if (rx_valid === 1'b1) begin
                valid_cnt = valid_cnt + 1;
                cap_prev  = cap_last;
                cap_last  = rx_d_out;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp)
        else begin
            errors = errors + 1;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        rx_d_in = b;
        repeat (BIT_CLK) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(par);
        send_bit(stop);
    endtask

    initial begin : stim
        int base;
        logic [7:0] byte81;

        // Reset state
        repeat (5) @(negedge clk);
        check("rst_data",  32'(rx_d_out),   32'h00);
        check("rst_valid", 32'(rx_valid),   32'h0);
        check("rst_perr",  32'(parity_err), 32'h0);
        check("rst_ferr",  32'(frame_err),  32'h0);
        check("rst_busy",  32'(rx_busy),    32'h0);
        rst = 1'b1;
        repeat (10) @(negedge clk);

        // 0xA5, even parity select, correct parity 0
        base  = valid_cnt;
        p_sel = 1'b1;
        fork
            send_frame(8'hA5, 1'b0, 1'b1);
            begin
                repeat (5 * BIT_CLK) @(negedge clk);
                check("a5_busy_mid", 32'(rx_busy), 32'h1);
            end
        join
        send_bit(1'b1);
        check("a5_count", 32'(valid_cnt - base), 32'd1);
        check("a5_data",  32'(rx_d_out),   32'hA5);
        check("a5_perr",  32'(parity_err), 32'h0);
        check("a5_ferr",  32'(frame_err),  32'h0);
        check("a5_busy",  32'(rx_busy),    32'h0);

        // 0x01, odd select, wrong parity 1; p_sel flips mid-frame and must be ignored
        base  = valid_cnt;
        p_sel = 1'b0;
        fork
            send_frame(8'h01, 1'b1, 1'b1);
            begin
                repeat (3 * BIT_CLK) @(negedge clk);
                p_sel = 1'b1;
            end
        join
        send_bit(1'b1);
        p_sel = 1'b1;
        check("p01_count", 32'(valid_cnt - base), 32'd1);
        check("p01_data",  32'(rx_d_out),   32'h01);
        check("p01_perr",  32'(parity_err), 32'h1);
        check("p01_ferr",  32'(frame_err),  32'h0);

        // 0x3C with low stop bit, then line held low for 3 bit times
        base = valid_cnt;
        send_frame(8'h3C, 1'b0, 1'b0);
        repeat (3 * BIT_CLK) @(negedge clk);
        check("brk_count", 32'(valid_cnt - base), 32'd1);
        check("brk_data",  32'(rx_d_out),   32'h3C);
        check("brk_ferr",  32'(frame_err),  32'h1);
        check("brk_perr",  32'(parity_err), 32'h0);
        check("brk_busy",  32'(rx_busy),    32'h1);
        rx_d_in = 1'b1;
        repeat (BIT_CLK) @(negedge clk);
        check("brk_idle",   32'(rx_busy),           32'h0);
        check("brk_count2", 32'(valid_cnt - base),  32'd1);

        // Glitch: 4 ticks low, then a good 0x55
        base    = valid_cnt;
        rx_d_in = 1'b0;
        repeat (4 * TICK_DIV) @(negedge clk);
        rx_d_in = 1'b1;
        repeat (2 * BIT_CLK) @(negedge clk);
        check("gl_count", 32'(valid_cnt - base), 32'd0);
        check("gl_busy",  32'(rx_busy),          32'h0);
        send_frame(8'h55, 1'b0, 1'b1);
        send_bit(1'b1);
        check("gl55_count", 32'(valid_cnt - base), 32'd1);
        check("gl55_data",  32'(rx_d_out),   32'h55);
        check("gl55_perr",  32'(parity_err), 32'h0);
        check("gl55_ferr",  32'(frame_err),  32'h0);

        // Back-to-back 0x00 then 0xFF with no idle bits
        base = valid_cnt;
        send_frame(8'h00, 1'b0, 1'b1);
        send_frame(8'hFF, 1'b0, 1'b1);
        send_bit(1'b1);
        check("b2b_count", 32'(valid_cnt - base), 32'd2);
        check("b2b_first", 32'(cap_prev),   32'h00);
        check("b2b_second",32'(cap_last),   32'hFF);
        check("b2b_perr",  32'(parity_err), 32'h0);
        check("b2b_ferr",  32'(frame_err),  32'h0);

        // Reset in the middle of data bit 4 of 0x81
        base   = valid_cnt;
        byte81 = 8'h81;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(byte81[i]);
        rx_d_in = byte81[4];
        repeat (BIT_CLK / 2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("mrst_data",  32'(rx_d_out),   32'h00);
        check("mrst_valid", 32'(rx_valid),   32'h0);
        check("mrst_perr",  32'(parity_err), 32'h0);
        check("mrst_ferr",  32'(frame_err),  32'h0);
        check("mrst_busy",  32'(rx_busy),    32'h0);
        rx_d_in = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        repeat (2 * BIT_CLK) @(negedge clk);
        check("mrst_count", 32'(valid_cnt - base), 32'd0);
        send_frame(8'h81, 1'b0, 1'b1);
        send_bit(1'b1);
        check("r81_count", 32'(valid_cnt - base), 32'd1);
        check("r81_data",  32'(rx_d_out),   32'h81);
        check("r81_perr",  32'(parity_err), 32'h0);
        check("r81_ferr",  32'(frame_err),  32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
